// File: rtl/req_responder_if.sv
// rtl/req_responder_if.sv - req/busy handshake bundle between initiator and responder
interface req_responder_if #(
  parameter int WIDTH = 4
) ();
  logic             req_i;
  logic [WIDTH-1:0] len_i;
  logic             abort_i;
  logic             busy_o;
  logic [WIDTH-1:0] count_o;
  logic             done_o;
  logic             pend_o;
  logic             drop_o;

  modport slave (
    input  req_i, len_i, abort_i,
    output busy_o, count_o, done_o, pend_o, drop_o
  );

  modport master (
    output req_i, len_i, abort_i,
    input  busy_o, count_o, done_o, pend_o, drop_o
  );
endinterface

// File: rtl/req_responder.sv
// rtl/req_responder.sv - responder: counts one job per req rising edge, one-deep pending slot
module req_responder #(
  parameter int WIDTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  req_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             req_q;
  logic [WIDTH-1:0] len_q, len_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_len_q, pend_len_d;
  logic             drop_q, drop_d;

  logic             event_w;
  logic             start_go;
  logic [WIDTH-1:0] start_len;

  assign event_w = bus.req_i & ~req_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      len_q      <= '0;
      count_q    <= '0;
      pend_q     <= 1'b0;
      pend_len_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= bus.req_i;
      len_q      <= len_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      pend_len_q <= pend_len_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    count_d    = count_q;
    pend_d     = pend_q;
    pend_len_d = pend_len_q;
    drop_d     = 1'b0;
    start_go   = 1'b0;
    start_len  = '0;

    case (state_q)
      S_IDLE: begin
        start_go  = event_w;
        start_len = bus.len_i;
      end
      S_RUN: begin
        count_d = count_q + WIDTH'(1);
        if (count_q == len_q - WIDTH'(1)) begin
          state_d = S_DONE;
          count_d = '0;
        end
        if (event_w) begin
          if (!pend_q) begin
            pend_d     = 1'b1;
            pend_len_d = bus.len_i;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (pend_q) begin
          // Draining the slot frees it, so a same-edge event refills it.
          start_go   = 1'b1;
          start_len  = pend_len_q;
          pend_d     = event_w;
          pend_len_d = event_w ? bus.len_i : pend_len_q;
        end else begin
          start_go  = event_w;
          start_len = bus.len_i;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_go) begin
      if (start_len != '0) begin
        state_d = S_RUN;
        len_d   = start_len;
        count_d = '0;
      end else begin
        state_d = S_DONE;
      end
    end

    if (bus.abort_i) begin
      state_d = S_IDLE;
      count_d = '0;
      pend_d  = 1'b0;
      drop_d  = 1'b0;
    end
  end

  assign bus.busy_o  = (state_q == S_RUN);
  assign bus.done_o  = (state_q == S_DONE);
  assign bus.count_o = count_q;
  assign bus.pend_o  = pend_q;
  assign bus.drop_o  = drop_q;

endmodule
